// File: rtl/buffer_access_arbiter_if.sv
// Handshake and buffer-control bundle between the endpoint buffer arbiter and its requesters.
// The master side drives requests and flush/clear; the slave side is the arbiter.
interface buffer_access_arbiter_if #(
    parameter int AW    = 6,
    parameter int OCC_W = 7
);
    logic             usb_rx_req;
    logic             usb_tx_req;
    logic             ahb_rd_req;
    logic             ahb_wr_req;
    logic             flush;
    logic             clear;
    logic             usb_rx_gnt;
    logic             usb_tx_gnt;
    logic             ahb_rd_gnt;
    logic             ahb_wr_gnt;
    logic             ahb_err;
    logic             buf_we;
    logic             buf_wsrc;
    logic [AW-1:0]    buf_waddr;
    logic             buf_re;
    logic             buf_rdst;
    logic [AW-1:0]    buf_raddr;
    logic [OCC_W-1:0] buffer_occupancy;

    modport master (
        output usb_rx_req, usb_tx_req, ahb_rd_req, ahb_wr_req, flush, clear,
        input  usb_rx_gnt, usb_tx_gnt, ahb_rd_gnt, ahb_wr_gnt, ahb_err,
        input  buf_we, buf_wsrc, buf_waddr, buf_re, buf_rdst, buf_raddr, buffer_occupancy
    );

    modport slave (
        input  usb_rx_req, usb_tx_req, ahb_rd_req, ahb_wr_req, flush, clear,
        output usb_rx_gnt, usb_tx_gnt, ahb_rd_gnt, ahb_wr_gnt, ahb_err,
        output buf_we, buf_wsrc, buf_waddr, buf_re, buf_rdst, buf_raddr, buffer_occupancy
    );
endinterface

// File: rtl/buffer_access_arbiter.sv
// Single-access-per-cycle arbiter for the USB endpoint buffer RAM; owns pointers and occupancy.
// Optional AHB anti-starvation guard is enabled by defining STARVE_GUARD_EN.
module buffer_access_arbiter #(
    parameter int DEPTH    = 64,
    parameter int AW       = 6,
    parameter int OCC_W    = 7
`ifdef STARVE_GUARD_EN
    ,parameter int MAX_WAIT = 8
`endif
) (
    input logic                    clk,
    input logic                    rst,
    buffer_access_arbiter_if.slave bus
);

    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             prio_rx_q, prio_rx_d;
    logic             prio_rd_q, prio_rd_d;

    logic is_empty, is_full, flush_any;
    logic rx_ok, tx_ok, rd_ok, wr_ok, usb_ok, ahb_ok;
    logic rx_gnt, tx_gnt, rd_gnt, wr_gnt, err;
    logic do_wr, do_rd, force_ahb;

    assign is_empty  = (occ_q == '0);
    assign is_full   = (occ_q == FULL_OCC);
    assign flush_any = bus.flush | bus.clear;
    assign rx_ok     = bus.usb_rx_req & ~is_full;
    assign tx_ok     = bus.usb_tx_req & ~is_empty;
    assign wr_ok     = bus.ahb_wr_req & ~is_full;
    assign rd_ok     = bus.ahb_rd_req & ~is_empty;
    assign usb_ok    = rx_ok | tx_ok;
    assign ahb_ok    = rd_ok | wr_ok;

`ifdef STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign force_ahb = ahb_ok & (wait_q == WAIT_W'(MAX_WAIT));

    // Counts cycles an eligible AHB request has been passed over; any AHB outcome or emptying resets it.
    always_comb begin
        wait_d = wait_q;
        if (flush_any || rd_gnt || wr_gnt || err) begin
            wait_d = '0;
        end else if (ahb_ok && (wait_q != WAIT_W'(MAX_WAIT))) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign force_ahb = 1'b0;
`endif

    // Grants are gated by reset so outputs are quiet while the block is held in reset.
    always_comb begin
        rx_gnt    = 1'b0;
        tx_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        wr_gnt    = 1'b0;
        err       = 1'b0;
        prio_rx_d = prio_rx_q;
        prio_rd_d = prio_rd_q;
        if (!rst && !flush_any) begin
            err = (bus.ahb_rd_req & is_empty) | (bus.ahb_wr_req & is_full);
            if (usb_ok && !force_ahb) begin
                if (rx_ok && (!tx_ok || prio_rx_q)) begin
                    rx_gnt = 1'b1;
                end else begin
                    tx_gnt = 1'b1;
                end
                prio_rx_d = ~prio_rx_q;
            end else if (ahb_ok) begin
                if (rd_ok && (!wr_ok || prio_rd_q)) begin
                    rd_gnt = 1'b1;
                end else begin
                    wr_gnt = 1'b1;
                end
                prio_rd_d = ~prio_rd_q;
            end
        end
    end

    assign do_wr = rx_gnt | wr_gnt;
    assign do_rd = tx_gnt | rd_gnt;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_any) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            occ_d    = occ_q + OCC_W'(1);
        end else if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            occ_d    = occ_q - OCC_W'(1);
        end
    end

    // Round-robin flags reset to 1 so usb_rx and ahb_rd win the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            prio_rx_q <= 1'b1;
            prio_rd_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            prio_rx_q <= prio_rx_d;
            prio_rd_q <= prio_rd_d;
        end
    end

    assign bus.usb_rx_gnt       = rx_gnt;
    assign bus.usb_tx_gnt       = tx_gnt;
    assign bus.ahb_rd_gnt       = rd_gnt;
    assign bus.ahb_wr_gnt       = wr_gnt;
    assign bus.ahb_err          = err;
    assign bus.buf_we           = do_wr;
    assign bus.buf_wsrc         = wr_gnt;
    assign bus.buf_waddr        = wr_ptr_q;
    assign bus.buf_re           = do_rd;
    assign bus.buf_rdst         = rd_gnt;
    assign bus.buf_raddr        = rd_ptr_q;
    assign bus.buffer_occupancy = occ_q;

endmodule
